// File: rtl/washer_sequencer.sv
// washer_sequencer: timed wash-cycle sequencer sitting between the front panel
// (start / cancel / mode / lid sensor) and the motor and valve drivers.
// Walks IDLE -> READY -> a mode-selected tail of SOAK/WASH/RINSE/SPIN, each
// phase timed in clock ticks, with a fill window at the start of every wet
// phase, lid-open pause, and cancel/abort handling.
//
// Optional feature macro: WASHER_LID_LOCK_EN
//   defined   -> adds output lid_lock (high in SPIN); lid_open ignored in SPIN
//   undefined -> no lid_lock port; lid_open pauses SPIN like any other phase
module washer_sequencer #(
  parameter int CNT_W      = 8,
  parameter int SOAK_T     = 20,
  parameter int WASH_T     = 40,
  parameter int RINSE_T    = 30,
  parameter int SPIN_T     = 25,
  parameter int FILL_T     = 10,
  parameter int RINSE_REPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       lid_open,
  input  logic [1:0] mode,
  output logic       idle_op,
  output logic       ready_op,
  output logic       soak_op,
  output logic       wash_op,
  output logic       rinse_op,
  output logic       spin_op,
  output logic       water_inlet,
  output logic       paused,
  output logic       coin_rtrn,
  output logic       done,
  output logic       aborted
`ifdef WASHER_LID_LOCK_EN
  ,
  output logic       lid_lock
`endif
);

  localparam int REP_W = (RINSE_REPS > 1) ? $clog2(RINSE_REPS) : 1;

  localparam logic [CNT_W-1:0] SOAK_LAST  = CNT_W'(SOAK_T - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_T - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_T - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_T - 1);
  localparam logic [CNT_W:0]   FILL_LIM   = (CNT_W + 1)'(FILL_T);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(RINSE_REPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5
  } state_e;

  state_e           state;
  state_e           next_state;
  logic [CNT_W-1:0] timer;
  logic [REP_W-1:0] rinse_cnt;
  logic             running;
  logic             wet;
  logic             lid_ignored;
  logic             phase_last;
  logic             phase_end;
  logic             rep_end;
  logic             coin_q;
  logic             done_q;
  logic             aborted_q;

  // Phase qualifiers: is a timed phase active, is the lid honoured, has the
  // current phase (or rinse repetition) reached its final tick.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    running     = 1'b0;
    wet         = 1'b0;
    phase_last  = 1'b0;
    lid_ignored = 1'b0;
    case (state)
      S_SOAK:  begin running = 1'b1; wet = 1'b1; phase_last = (timer == SOAK_LAST);  end
      S_WASH:  begin running = 1'b1; wet = 1'b1; phase_last = (timer == WASH_LAST);  end
      S_RINSE: begin running = 1'b1; wet = 1'b1; phase_last = (timer == RINSE_LAST); end
      S_SPIN:  begin
        running    = 1'b1;
        phase_last = (timer == SPIN_LAST);
`ifdef WASHER_LID_LOCK_EN
        lid_ignored = 1'b1;
`endif
      end
      default: ;
    endcase
    paused    = running && lid_open && !lid_ignored;
    phase_end = running && !paused && phase_last;
    rep_end   = (state == S_RINSE) && phase_end && (rinse_cnt != REP_LAST);
  end

  // State register; an async reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. The selected mode only picks the entry phase; after
  // that the order is fixed, so the state itself carries the latched mode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_READY;
      S_READY: begin
        if (cancel) next_state = S_IDLE;
        else begin
          case (mode)
            2'd1:    next_state = S_SOAK;
            2'd2:    next_state = S_WASH;
            2'd3:    next_state = S_RINSE;
            default: next_state = S_READY;
          endcase
        end
      end
      S_SOAK:  if (cancel) next_state = S_IDLE; else if (phase_end) next_state = S_WASH;
      S_WASH:  if (cancel) next_state = S_IDLE; else if (phase_end) next_state = S_RINSE;
      S_RINSE: begin
        if (cancel) next_state = S_IDLE;
        else if (phase_end && rinse_cnt == REP_LAST) next_state = S_SPIN;
      end
      S_SPIN:  if (cancel || phase_end) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Phase timer, rinse repetition count and the one-cycle event pulses that
  // land in the first IDLE cycle after the transition that caused them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      rinse_cnt <= '0;
      coin_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (next_state != state || rep_end) timer <= '0;
      else if (running && !paused)        timer <= timer + 1'b1;

      if (next_state != S_RINSE) rinse_cnt <= '0;
      else if (rep_end)          rinse_cnt <= rinse_cnt + 1'b1;

      coin_q    <= (state == S_READY) && cancel;
      aborted_q <= running && cancel;
      done_q    <= (state == S_SPIN) && phase_end && !cancel;
    end
  end

  // Output decode: one-hot phase flags from the state register, fill valve
  // gated by the fill window and the lid pause.
  always_comb begin
    idle_op     = (state == S_IDLE);
    ready_op    = (state == S_READY);
    soak_op     = (state == S_SOAK);
    wash_op     = (state == S_WASH);
    rinse_op    = (state == S_RINSE);
    spin_op     = (state == S_SPIN);
    water_inlet = wet && ({1'b0, timer} < FILL_LIM) && !paused;
    coin_rtrn   = coin_q;
    done        = done_q;
    aborted     = aborted_q;
`ifdef WASHER_LID_LOCK_EN
    lid_lock    = (state == S_SPIN);
`endif
  end

endmodule

// File: tb/tb_washer_sequencer.sv
// tb_washer_sequencer: directed scenarios plus randomized stimulus, every
// cycle compared against a phase-plan reference model (a queue of timed steps).
module tb_washer_sequencer;

  localparam int SOAK_T     = 4;
  localparam int WASH_T     = 5;
  localparam int RINSE_T    = 3;
  localparam int SPIN_T     = 2;
  localparam int FILL_T     = 2;
  localparam int RINSE_REPS = 2;
`ifdef WASHER_LID_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cancel;
  logic       lid_open;
  logic [1:0] mode;
  logic       idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op;
  logic       water_inlet, paused, coin_rtrn, done, aborted;
`ifdef WASHER_LID_LOCK_EN
  logic       lid_lock;
`endif

  washer_sequencer #(
    .CNT_W(8), .SOAK_T(SOAK_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
    .SPIN_T(SPIN_T), .FILL_T(FILL_T), .RINSE_REPS(RINSE_REPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .lid_open(lid_open),
    .mode(mode), .idle_op(idle_op), .ready_op(ready_op), .soak_op(soak_op),
    .wash_op(wash_op), .rinse_op(rinse_op), .spin_op(spin_op),
    .water_inlet(water_inlet), .paused(paused), .coin_rtrn(coin_rtrn),
    .done(done), .aborted(aborted)
`ifdef WASHER_LID_LOCK_EN
    , .lid_lock(lid_lock)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A session is a plan: a queue of (phase, duration) steps built from the
  // selected mode. Time within the head step advances unless the lid pauses it.
  typedef enum int {PH_SOAK, PH_WASH, PH_RINSE, PH_SPIN} phase_t;
  typedef struct {
    phase_t ph;
    int     dur;
  } step_t;

  step_t plan[$];
  int    elapsed;
  int    where;      // 0 = idle, 1 = ready, 2 = running the plan
  bit    m_coin, m_done, m_abort;

  function automatic void model_reset();
    where   = 0;
    elapsed = 0;
    plan.delete();
    m_coin  = 0;
    m_done  = 0;
    m_abort = 0;
  endfunction

  function automatic bit model_paused(input logic l);
    if (where != 2 || plan.size() == 0) return 1'b0;
    return l && !(LOCK_EN && plan[0].ph == PH_SPIN);
  endfunction

  // Packed as {idle,ready,soak,wash,rinse,spin,water,paused,coin,done,aborted,lid_lock}
  function automatic logic [11:0] model_out(input logic l);
    bit     run = (where == 2) && (plan.size() > 0);
    phase_t ph  = PH_SOAK;
    bit     pz  = model_paused(l);
    bit     wat;
    if (run) ph = plan[0].ph;
    wat = run && ph != PH_SPIN && elapsed < FILL_T && !pz;
    return {where == 0, where == 1, run && ph == PH_SOAK, run && ph == PH_WASH,
            run && ph == PH_RINSE, run && ph == PH_SPIN, wat, pz,
            m_coin, m_done, m_abort, LOCK_EN && run && ph == PH_SPIN};
  endfunction

  function automatic void model_step(input logic s, input logic c, input logic l,
                                     input logic [1:0] m);
    bit pz = model_paused(l);
    m_coin  = 0;
    m_done  = 0;
    m_abort = 0;
    case (where)
      0: if (s) where = 1;
      1: begin
        if (c) begin
          where  = 0;
          m_coin = 1;
        end else if (m != 2'd0) begin
          plan.delete();
          if (m == 2'd1) plan.push_back('{PH_SOAK, SOAK_T});
          if (m <= 2'd2) plan.push_back('{PH_WASH, WASH_T});
          for (int r = 0; r < RINSE_REPS; r++) plan.push_back('{PH_RINSE, RINSE_T});
          plan.push_back('{PH_SPIN, SPIN_T});
          elapsed = 0;
          where   = 2;
        end
      end
      default: begin
        if (c) begin
          where   = 0;
          m_abort = 1;
          plan.delete();
          elapsed = 0;
        end else if (!pz) begin
          elapsed++;
          if (elapsed == plan[0].dur) begin
            void'(plan.pop_front());
            elapsed = 0;
            if (plan.size() == 0) begin
              where  = 0;
              m_done = 1;
            end
          end
        end
      end
    endcase
  endfunction

  function automatic logic [11:0] dut_out();
    logic ll;
`ifdef WASHER_LID_LOCK_EN
    ll = lid_lock;
`else
    ll = 1'b0;
`endif
    return {idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op,
            water_inlet, paused, coin_rtrn, done, aborted, ll};
  endfunction

  // ---------------- stimulus ----------------
  string tag;
  int    cyc;
  int    done_cyc, coin_cyc, abort_cyc;
  int    water_cnt, pause_cnt;

  task automatic begin_test(input string name);
    tag       = name;
    cyc       = 0;
    done_cyc  = -1;
    coin_cyc  = -1;
    abort_cyc = -1;
    water_cnt = 0;
    pause_cnt = 0;
  endtask

  task automatic cycle_step(input logic s, input logic c, input logic l, input logic [1:0] m);
    @(negedge clk);
    start    = s;
    cancel   = c;
    lid_open = l;
    mode     = m;
    #1;
    check($sformatf("%s cyc%0d", tag, cyc), dut_out(), model_out(l));
    if (done === 1'b1)        done_cyc  = cyc;
    if (coin_rtrn === 1'b1)   coin_cyc  = cyc;
    if (aborted === 1'b1)     abort_cyc = cyc;
    if (water_inlet === 1'b1) water_cnt++;
    if (paused === 1'b1)      pause_cnt++;
    model_step(s, c, l, m);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; lid_open = 1'b0; mode = 2'd0;
    model_reset();
    #12;
    check("reset_state", dut_out(), 12'h800);
    @(negedge clk);
    rst = 1'b0;

    // Full run, mode 1
    begin_test("full");
    cycle_step(1, 0, 0, 0);
    cycle_step(0, 0, 0, 1);
    repeat (19) cycle_step(0, 0, 0, 0);
    check("full_done_cycle", done_cyc, 19);
    check("full_fill_cycles", water_cnt, 8);

    // Quick run, mode 3 (lid raised during SPIN when the lock is built in)
    begin_test("quick");
    cycle_step(1, 0, 0, 0);
    cycle_step(0, 0, 0, 3);
    for (int k = 2; k < 12; k++) cycle_step(0, 0, LOCK_EN && (k == 8 || k == 9), 0);
    check("quick_done_cycle", done_cyc, 10);
    check("quick_pause_cycles", pause_cnt, 0);

    // Cancel in READY, then mode alone must not start anything
    begin_test("cancel_ready");
    cycle_step(1, 0, 0, 0);
    cycle_step(0, 1, 0, 0);
    repeat (4) cycle_step(0, 0, 0, 1);
    check("cancel_ready_coin_cycle", coin_cyc, 2);
    check("cancel_ready_abort", abort_cyc, -1);

    // Lid pause in WASH cycles 7..9
    begin_test("lid_pause");
    cycle_step(1, 0, 0, 0);
    cycle_step(0, 0, 0, 1);
    for (int k = 2; k < 24; k++) cycle_step(0, 0, (k >= 7 && k <= 9), 0);
    check("lid_pause_done_cycle", done_cyc, 22);
    check("lid_pause_cycles", pause_cnt, 3);

    // Cancel together with lid_open inside RINSE
    begin_test("cancel_rinse");
    cycle_step(1, 0, 0, 0);
    cycle_step(0, 0, 0, 3);
    cycle_step(0, 0, 0, 0);
    cycle_step(0, 1, 1, 0);
    repeat (3) cycle_step(0, 0, 0, 0);
    check("cancel_rinse_abort_cycle", abort_cyc, 4);
    check("cancel_rinse_done", done_cyc, -1);
    check("cancel_rinse_coin", coin_cyc, -1);

    // Async reset between edges in SPIN
    begin_test("rst_spin");
    cycle_step(1, 0, 0, 0);
    cycle_step(0, 0, 0, 3);
    for (int k = 2; k < 9; k++) cycle_step(0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_spin", dut_out(), 12'h800);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    begin_test("rand");
    for (int k = 0; k < 600; k++) begin
      cycle_step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/washer_sequencer.md
Name: washer_sequencer

Overview:
Parametrised, timed wash-cycle sequencer for the laundromat controller family. It walks IDLE -> READY -> a mode-selected subset of SOAK/WASH/RINSE/SPIN.
- Each phase has a programmable duration in clock ticks.
- Rinse repeats a configurable number of times.
- Water fill is a timed sub-window at the start of each wet phase.
- Lid-open pauses the current phase and it resumes on close. Cancel aborts the run.
- It sits between the coin/selector front panel and the motor/valve drivers.

Parameters:
CNT_W, 8, phase timer width; every *_T parameter must be < 2**CNT_W.
SOAK_T, 20, SOAK duration in cycles (>=1).
WASH_T, 40, WASH duration in cycles (>=1).
RINSE_T, 30, duration of one rinse repetition (>=1).
SPIN_T, 25, SPIN duration in cycles (>=1).
FILL_T, 10, water_inlet window at the start of each SOAK/WASH/RINSE repetition. Must be 0..min(SOAK_T,WASH_T,RINSE_T).
RINSE_REPS, 2, number of rinse repetitions (>=1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a session; honoured only in IDLE
cancel  in  1  abort; coin return if in READY
lid_open  in  1  lid sensor; 1 = open
mode  in  2  1 = full (SOAK,WASH,RINSE,SPIN), 2 = normal (WASH,RINSE,SPIN), 3 = quick (RINSE,SPIN), 0 = none
idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op  out  1 each  one-hot phase indicators, decoded from the state register
water_inlet  out  1  fill valve
paused  out  1  phase timer frozen by lid_open
coin_rtrn  out  1  1-cycle pulse
done  out  1  1-cycle pulse on normal completion
aborted  out  1  1-cycle pulse on cancel of a running cycle

Behaviour:
- Reset (async): state = IDLE, timer = 0, rinse count = 0. Outputs: idle_op = 1; all other outputs = 0.
- IDLE: start=1 -> READY on the next edge.
- READY priority, highest first:
  - cancel: -> IDLE; coin_rtrn = 1 for exactly the first IDLE cycle.
  - mode != 0: mode is latched; move to the first phase of that mode on the next edge.
  - otherwise: stay in READY.
- Running phase (SOAK/WASH/RINSE/SPIN):
  - The timer clears to 0 on phase entry and on each new rinse repetition.
  - It increments each cycle when not paused. The phase ends on the cycle timer == T-1 with no pause.
  - Each phase therefore occupies exactly T un-paused cycles.
- Phase order:
  - SOAK -> WASH -> RINSE.
  - RINSE repeats RINSE_REPS times without leaving the RINSE state; rinse_op stays 1 across repetitions.
  - RINSE -> SPIN -> IDLE.
  - done = 1 in the first IDLE cycle after SPIN.
- water_inlet = 1 when the state is SOAK, WASH or RINSE, timer < FILL_T, and paused = 0. FILL_T = 0 means never.
- Lid pause:
  - lid_open = 1 in a running phase: paused = 1 in that same cycle (combinational from lid_open and state). The timer holds and water_inlet is forced to 0.
  - lid_open = 0: counting resumes that cycle.
  - lid_open has no effect in IDLE or READY.
- Cancel in a running phase: -> IDLE next edge; aborted = 1 in the first IDLE cycle; done stays 0; coin_rtrn stays 0.
- Simultaneous events:
  - cancel beats lid_open and beats phase completion.
  - start outside IDLE is ignored.
  - A mode change after READY is ignored (the latched mode is used).
- Invalid state encodings recover to IDLE on the next edge.
- Async rst mid-run: everything returns to reset values immediately, with no done/aborted pulse.

Optional Feature:
WASHER_LID_LOCK_EN
- Defined: adds output lid_lock (1 bit), = 1 while in SPIN and 0 elsewhere (reset 0). lid_open is ignored during SPIN: no pause, paused stays 0.
- Undefined: port absent; lid_open pauses SPIN exactly like the other phases.

Test Plan:
Bench parameters: SOAK_T=4, WASH_T=5, RINSE_T=3, SPIN_T=2, FILL_T=2, RINSE_REPS=2, macro undefined unless stated. Cycle numbers are counted from the edge that samples start.
1. Full run (mode 1): start at cycle 0, mode=1 at cycle 1 -> SOAK cycles 2-5, WASH 6-10, RINSE 11-16, SPIN 17-18, done=1 and idle_op=1 at cycle 19. water_inlet=1 in cycles 2-3, 6-7, 11-12 and 14-15 only.
2. Quick run (mode 3): start at 0, mode=3 at 1 -> RINSE 2-7, SPIN 8-9, done at 10; soak_op and wash_op never asserted.
3. Cancel in READY: start at 0, cancel at 1 -> idle_op=1 and coin_rtrn=1 at cycle 2 only; aborted=0; mode asserted later is ignored until a new start.
4. Lid pause: full run, lid_open high for 3 cycles starting at WASH cycle 2 (timer=1) -> paused=1 for those 3 cycles, timer holds at 1, water_inlet=0, WASH lasts 8 cycles total, done at cycle 22.
5. Cancel+lid_open in the same RINSE cycle -> IDLE next edge, aborted one-cycle pulse, done=0, coin_rtrn=0.
6. rst asserted mid-SPIN between edges -> idle_op=1 and all other outputs 0 immediately. With WASHER_LID_LOCK_EN: lid_open during SPIN gives lid_lock=1, paused=0, and SPIN still lasts 2 cycles.
